// File: rtl/weight_updater_if.sv
// +------------------------------------------------------------------------+
// | weight_updater_if : start/done control and weight-RAM port bundle      |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

interface weight_updater_if #(
  parameter int AW = 10,
  parameter int W  = 24,
  parameter int TW = 8
);
  logic          start;
  logic          post_spike;
  logic [AW-1:0] addr_r;
  logic [W-1:0]  data_r;
  logic [TW-1:0] trace_in;
  logic [AW-1:0] addr_w;
  logic [W-1:0]  data_w;
  logic          we;
  logic          busy;
  logic          done;
  logic [AW-1:0] sat_count;

  // Controller plus RAM side of the bundle.
  modport master (
    output start, post_spike, data_r, trace_in,
    input  addr_r, addr_w, data_w, we, busy, done, sat_count
  );

  // Weight updater side of the bundle.
  modport slave (
    input  start, post_spike, data_r, trace_in,
    output addr_r, addr_w, data_w, we, busy, done, sat_count
  );
endinterface

`default_nettype wire

// File: rtl/weight_updater.sv
// +------------------------------------------------------------------------+
// | weight_updater : one STDP read-modify-write pass over a weight RAM     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module weight_updater #(
  parameter int M       = 784,
  parameter int W       = 24,
  parameter int AW      = 10,
  parameter int TW      = 8,
  parameter int A_PLUS  = 16,
  parameter int A_MINUS = 8,
  parameter int WMAX    = 65536,
  parameter int WMIN    = -65536
) (
  input  logic           clk,
  input  logic           rst,
  weight_updater_if.slave bus
);

  localparam int EW = W + TW + 2;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  localparam logic [AW-1:0]        C_LAST = AW'(M - 1);
  localparam logic signed [EW-1:0] C_WMAX = EW'(WMAX);
  localparam logic signed [EW-1:0] C_WMIN = EW'(WMIN);
  localparam logic signed [EW-1:0] C_DEC  = EW'(-A_MINUS);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          drain_q, drain_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] sat_q, sat_d;
  logic          s1_vld_q, s1_vld_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_w_q, addr_w_d;
  logic [W-1:0]  data_w_q, data_w_d;

  logic                 sat_clr;
  logic [EW-1:0]        prod;
  logic signed [EW-1:0] w_ext, delta, sum, clamped;
  logic                 sat_hit;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    drain_d  = drain_q;
    mode_d   = mode_q;
    sat_clr  = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (bus.start) begin
          state_d  = C_RUN;
          mode_d   = bus.post_spike;
          rd_cnt_d = '0;
          sat_clr  = 1'b1;
        end
      end
      C_RUN: begin
        if (rd_cnt_q == C_LAST) begin
          state_d = C_DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_cnt_d = rd_cnt_q + AW'(1);
        end
      end
      C_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = C_DONE;
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Stage 2: widen, apply the STDP rule without wrap, then clamp.
  always_comb begin
    w_ext = {{(EW-W){bus.data_r[W-1]}}, bus.data_r};
    prod  = EW'(bus.trace_in) * EW'(A_PLUS);
    if (mode_q && (bus.trace_in != '0))      delta = $signed(prod);
    else if (mode_q || (bus.trace_in != '0)) delta = C_DEC;
    else                                     delta = '0;
    sum = w_ext + delta;
    if (sum > C_WMAX)      clamped = C_WMAX;
    else if (sum < C_WMIN) clamped = C_WMIN;
    else                   clamped = sum;
    sat_hit = (clamped != sum);
  end

  always_comb begin
    s1_vld_d  = (state_q == C_RUN);
    s1_addr_d = rd_cnt_q;
    we_d      = s1_vld_q;
    addr_w_d  = s1_vld_q ? s1_addr_q : addr_w_q;
    data_w_d  = s1_vld_q ? clamped[W-1:0] : data_w_q;
    sat_d     = sat_q;
    if (sat_clr)                                  sat_d = '0;
    else if (s1_vld_q && sat_hit && (sat_q != '1)) sat_d = sat_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= C_IDLE;
      rd_cnt_q  <= '0;
      drain_q   <= 1'b0;
      mode_q    <= 1'b0;
      sat_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      we_q      <= 1'b0;
      addr_w_q  <= '0;
      data_w_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      drain_q   <= drain_d;
      mode_q    <= mode_d;
      sat_q     <= sat_d;
      s1_vld_q  <= s1_vld_d;
      s1_addr_q <= s1_addr_d;
      we_q      <= we_d;
      addr_w_q  <= addr_w_d;
      data_w_q  <= data_w_d;
    end
  end

  assign bus.addr_r    = rd_cnt_q;
  assign bus.addr_w    = addr_w_q;
  assign bus.data_w    = data_w_q;
  assign bus.we        = we_q;
  assign bus.busy      = (state_q == C_RUN) || (state_q == C_DRAIN);
  assign bus.done      = (state_q == C_DONE);
  assign bus.sat_count = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_updater.sv
// +------------------------------------------------------------------------+
// | tb_weight_updater : directed and random passes against an STDP model   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_weight_updater;
  localparam int M       = 8;
  localparam int W       = 24;
  localparam int AW      = 10;
  localparam int TW      = 8;
  localparam int A_PLUS  = 16;
  localparam int A_MINUS = 8;
  localparam int WMAX    = 65536;
  localparam int WMIN    = -65536;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_updater_if #(.AW(AW), .W(W), .TW(TW)) bus ();

  weight_updater #(
    .M(M), .W(W), .AW(AW), .TW(TW), .A_PLUS(A_PLUS), .A_MINUS(A_MINUS),
    .WMAX(WMAX), .WMIN(WMIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0]  mem    [M];
  logic [W-1:0]  seed_w [M];
  logic [TW-1:0] tr     [M];
  logic          do_load;
  int total = 0;
  int bad   = 0;

  // Weight RAM and trace memory with one-cycle read latency.
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < M; i++) mem[i] <= seed_w[i];
    end else if (bus.we && int'(bus.addr_w) < M) begin
      mem[int'(bus.addr_w)] <= bus.data_w;
    end
    if (int'(bus.addr_r) < M) begin
      bus.data_r   <= mem[int'(bus.addr_r)];
      bus.trace_in <= tr[int'(bus.addr_r)];
    end
  end

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint stdp_raw(input longint w, input int t, input bit md);
    if (md && t != 0) return w + longint'(t) * A_PLUS;
    if (md || t != 0) return w - A_MINUS;
    return w;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > WMAX) return WMAX;
    if (v < WMIN) return WMIN;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic rand_seed();
    for (int i = 0; i < M; i++) begin
      seed_w[i] = W'(int'($urandom_range(0, 140000)) - 70000);
      tr[i]     = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 255));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},     bus.we,        0);
    chk({tag, "_busy"},   bus.busy,      0);
    chk({tag, "_done"},   bus.done,      0);
    chk({tag, "_addr_r"}, bus.addr_r,    0);
    chk({tag, "_addr_w"}, bus.addr_w,    0);
    chk({tag, "_data_w"}, bus.data_w,    0);
    chk({tag, "_sat"},    bus.sat_count, 0);
  endtask

  // Called at a negedge in idle; start is raised in this cycle (cycle s).
  task automatic run_pass(input bit md, input bit retrig, input int rst_cut);
    longint snap [M];
    longint expv [M];
    longint raw;
    int     nsat = 0;
    int     nwr;
    for (int k = 0; k < M; k++) begin
      snap[k] = sx(mem[k]);
      raw     = stdp_raw(snap[k], int'(tr[k]), md);
      expv[k] = clampv(raw);
      if (expv[k] != raw) nsat++;
    end
    if (nsat > 2**AW - 1) nsat = 2**AW - 1;
    bus.start      = 1'b1;
    bus.post_spike = md;
    for (int c = 1; c <= M + 3; c++) begin
      @(negedge clk);
      bus.start      = 1'b0;
      bus.post_spike = 1'($urandom_range(0, 1));
      if (rst_cut != 0 && c == rst_cut + 1) begin
        rst = 1'b0;
        chk_reset_outputs("midrst");
        break;
      end
      chk("busy", bus.busy, (c <= M + 2));
      chk("done", bus.done, (c == M + 3));
      chk("we",   bus.we,   (c >= 3 && c <= M + 2));
      if (c >= 3 && c <= M + 2) begin
        chk("addr_w", bus.addr_w, c - 3);
        chk("data_w", sx(bus.data_w), expv[c-3]);
      end
      if (c <= M)     chk("addr_r", bus.addr_r, c - 1);
      if (c == 1)     chk("sat_clr", bus.sat_count, 0);
      if (c == M + 3) chk("sat_count", bus.sat_count, nsat);
      if (retrig && (c == 2 || c == M + 3)) bus.start = 1'b1;
      if (rst_cut != 0 && c == rst_cut) rst = 1'b1;
    end
    if (rst_cut == 0) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("idle_busy", bus.busy, 0);
      chk("idle_we",   bus.we,   0);
      chk("sat_hold",  bus.sat_count, nsat);
    end
    nwr = (rst_cut != 0) ? rst_cut - 2 : M;
    for (int k = 0; k < M; k++)
      chk("mem", sx(mem[k]), (k < nwr) ? expv[k] : snap[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.post_spike = 1'b0;
    do_load        = 1'b0;
    for (int i = 0; i < M; i++) begin
      seed_w[i] = '0;
      tr[i]     = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    load_mem();

    // LTP
    rand_seed();
    seed_w[0] = 24'd100; seed_w[1] = 24'd100; seed_w[2] = 24'd100; seed_w[3] = 24'd100;
    tr[0] = 8'd3; tr[1] = 8'd0; tr[2] = 8'd1; tr[3] = 8'd0;
    load_mem();
    run_pass(1'b1, 1'b0, 0);
    chk("ltp0", sx(mem[0]), 148);
    chk("ltp1", sx(mem[1]), 92);
    chk("ltp2", sx(mem[2]), 116);
    chk("ltp3", sx(mem[3]), 92);

    // LTD
    rand_seed();
    seed_w[0] = W'(100); seed_w[1] = W'(-5); seed_w[2] = W'(0); seed_w[3] = W'(7);
    tr[0] = 8'd2; tr[1] = 8'd0; tr[2] = 8'd5; tr[3] = 8'd0;
    load_mem();
    run_pass(1'b0, 1'b0, 0);
    chk("ltd0", sx(mem[0]), 92);
    chk("ltd1", sx(mem[1]), -5);
    chk("ltd2", sx(mem[2]), -8);
    chk("ltd3", sx(mem[3]), 7);

    // Saturation at both bounds
    for (int i = 0; i < M; i++) begin
      seed_w[i] = '0;
      tr[i]     = 8'd1;
    end
    seed_w[0] = W'(65530);  tr[0] = 8'd255;
    seed_w[1] = W'(-65530); tr[1] = 8'd0;
    load_mem();
    run_pass(1'b1, 1'b0, 0);
    chk("sat_hi", sx(mem[0]), 65536);
    chk("sat_lo", sx(mem[1]), -65536);
    chk("sat_n",  bus.sat_count, 2);

    // Ignored re-trigger, then a start in the first idle cycle
    rand_seed();
    load_mem();
    run_pass(1'($urandom_range(0, 1)), 1'b1, 0);
    run_pass(1'b1, 1'b0, 0);
    for (int i = 0; i < M; i++) tr[i] = TW'($urandom_range(0, 255));
    run_pass(1'b0, 1'b0, 0);

    // Reset mid-run, then a clean pass
    rand_seed();
    load_mem();
    run_pass(1'b1, 1'b0, 4);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_we", bus.we, 0);
    end
    run_pass(1'b0, 1'b0, 0);

    // start and rst together
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    @(negedge clk);
    chk("rst_start_busy2", bus.busy, 0);

    // Random passes
    for (int n = 0; n < 6; n++) begin
      rand_seed();
      load_mem();
      run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/weight_updater.md
# weight_updater

Sequencer that drives the read and write ports of the per-neuron weight RAM and applies one STDP learning pass per image. On `start`, it streams every synapse address 0..M-1 through the RAM read port and a parallel presynaptic-trace read port. It computes each new weight, saturates it, and writes it back at one synapse per cycle. It sits between the core controller (`start`/`done`) and one weight RAM instance.

## Interface
- `M`, 784: number of synapses and RAM depth.
- `W`, 24: weight width, signed two's complement.
- `AW`, 10: address width.
- `TW`, 8: presynaptic trace width, unsigned.
- `A_PLUS`, 16: potentiation gain, unsigned.
- `A_MINUS`, 8: depression step, unsigned.
- `WMAX`, 65536: upper saturation bound, signed.
- `WMIN`, -65536: lower saturation bound, signed.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; only accepted in IDLE.
- `post_spike`  in  1  postsynaptic neuron fired this image; sampled when `start` is accepted.
- `addr_r`  out  AW  RAM read address.
- `data_r`  in  W  RAM read data; valid one cycle after `addr_r`.
- `trace_in`  in  TW  trace for address `addr_r`; same one-cycle latency as `data_r`.
- `addr_w`  out  AW  RAM write address.
- `data_w`  out  W  RAM write data.
- `we`  out  1  RAM write strobe.
- `busy`  out  1  pass in progress.
- `done`  out  1  one-cycle pulse when the last write has been issued.
- `sat_count`  out  AW  number of saturated writes in the current or last pass.

## Operation
- States:
  - IDLE: `start` → RUN. Latch `post_spike` into `mode`, clear `rd_cnt`, clear `sat_count`.
  - RUN: issue `addr_r = rd_cnt` and increment each cycle. When `rd_cnt` reaches M-1 → DRAIN.
  - DRAIN: 2 cycles, flushing the read and write pipeline → DONE.
  - DONE: 1 cycle, `done` = 1 → IDLE.
- Pipeline: stage 1 is the registered `addr_r`. Stage 2 receives `data_r`/`trace_in` and computes. Stage 3 holds the registered `addr_w`/`data_w`/`we`.
- Update rule, with `w = data_r` and `t = trace_in`:
  - `mode` = 1, t ≠ 0: w + t·A_PLUS.
  - `mode` = 1, t = 0: w − A_MINUS.
  - `mode` = 0, t ≠ 0: w − A_MINUS.
  - `mode` = 0, t = 0: w, written back unchanged.
- Arithmetic: sign-extend w to W+TW+2 bits and compute the sum at that width without wrap. Clamp to [WMIN, WMAX] and truncate to W bits. When clamping changes the value, `sat_count` += 1, saturating at 2^AW−1.
- Every address 0..M-1 is written exactly once per pass, in ascending order. `addr_w` never equals the `addr_r` issued in the same cycle, so there is no read-during-write hazard.
- `start` while `busy` or in DONE is ignored. `mode` does not change mid-pass.
- `addr_r` wraps to 0 only via a new pass, never mid-pass.

## Timing
- Reset values: all outputs are 0 (`addr_r`, `addr_w`, `data_w`, `we`, `busy`, `done`, `sat_count`), state is IDLE.
- `start` high in cycle s, while in IDLE:
  - `busy` = 1 for cycles s+1..s+M+2.
  - `addr_r` = k in cycle s+1+k.
  - `we` = 1 with `addr_w` = k in cycle s+3+k; `we` is high for exactly M contiguous cycles.
  - `done` = 1 in cycle s+M+3, with `busy` = 0 in that cycle.
  - `start` is next accepted in cycle s+M+4.
  - Total: M+3 cycles from `start` to `done`.
- `rst` in any cycle: from the next cycle all outputs are 0 and state is IDLE. `we` never asserts after reset. Weights already written stay modified; no rollback.
- `start` and `rst` high together: reset wins.
- `sat_count` holds its final value after DONE until the next accepted `start`.

## Test plan
- LTP, M=4, weights {100,100,100,100}, traces {3,0,1,0}, `post_spike`=1 → writes {148,92,116,92}, `done` at s+7, `sat_count`=0.
- LTD, `post_spike`=0, weights {100,−5,0,7}, traces {2,0,5,0} → writes {92,−5,−8,7}.
- Saturation: `post_spike`=1, weight 65530, trace 255 → writes 65536. Weight −65530, trace 0, A_MINUS=8 → writes −65536. `sat_count`=2.
- Re-trigger: `start` pulsed at s+2 and at s+M+3 → ignored; exactly M writes, one `done`. A `start` at s+M+4 launches a second pass.
- Reset mid-run: `rst` at s+4 with M=8 → `we` = 0 and `busy` = 0 from s+5. Addresses 0 and 1 are written; addresses 2..7 are untouched. The next `start` completes a full pass normally.
- Back-to-back: two passes, second with a different `post_spike` → `mode` follows each pass's sampled value. The second pass reads the weights written by the first.
